// File: rtl/tinker_mem_ctrl.sv
// Two-port (fetch + data) multi-cycle byte-memory controller with fixed wait states.
// Optional macro TINKER_MEM_ALIGN_CHECK_EN turns misaligned accesses into faults.
module tinker_mem_ctrl #(
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic              if_fault,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_fault
);

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned MEM_BYTES = 1 << ADDR_W;
  localparam int unsigned WORD_W    = 64;
  localparam logic [ADDR_W:0] ADDR_LIMIT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {PORT_FETCH, PORT_DATA} port_t;

  logic [7:0] mem [MEM_BYTES];

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  port_t               last_gnt;
  port_t               gnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          size_q;
  logic                we_q;
  logic [WORD_W-1:0]   wdata_q;

  logic [3:0]          nbytes;
  logic [ADDR_W:0]     end_addr;
  logic                range_err;
  logic                size_err;
  logic                align_err;
  logic                fault;
  logic [WORD_W-1:0]   rd_word;
  logic [WORD_W-1:0]   rd_data;
  logic                pick_data;
  logic                wr_en;

  // Fault classification of the latched transaction.
  always_comb begin
    nbytes    = 4'(1) << size_q;
    end_addr  = {1'b0, addr_q} + (ADDR_W+1)'(nbytes);
    range_err = end_addr > ADDR_LIMIT;
    size_err  = (size_q == 2'd3) && (DATA_W == 32);
`ifdef TINKER_MEM_ALIGN_CHECK_EN
    align_err = (addr_q & ADDR_W'(nbytes - 4'd1)) != '0;
`else
    align_err = 1'b0;
`endif
    fault     = range_err | size_err | align_err;
  end

  // Little-endian gather of the addressed bytes; bytes beyond the size stay zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < nbytes) rd_word[8*i +: 8] = mem[addr_q + ADDR_W'(i)];
    end
    rd_data = fault ? '0 : rd_word;
  end

  // On a conflict the port that lost last time wins; first conflict goes to data.
  assign pick_data = d_req && (!if_req || last_gnt == PORT_FETCH);
  assign wr_en     = (state == RESP) && (gnt_q == PORT_DATA) && we_q && !fault;

  // Byte array has no reset; an async reset forces IDLE so an aborted store never commits.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < nbytes) mem[addr_q + ADDR_W'(i)] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      last_gnt <= PORT_FETCH;
      gnt_q    <= PORT_FETCH;
      addr_q   <= '0;
      size_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      if_ready <= 1'b0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_fault <= 1'b0;
      d_ready  <= 1'b0;
      d_valid  <= 1'b0;
      d_rdata  <= '0;
      d_fault  <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            cnt   <= CNT_W'(WAIT_STATES);
            state <= (WAIT_STATES == 0) ? RESP : BUSY;
            if (pick_data) begin
              d_ready  <= 1'b1;
              gnt_q    <= PORT_DATA;
              last_gnt <= PORT_DATA;
              addr_q   <= d_addr;
              size_q   <= d_size;
              we_q     <= d_we;
              wdata_q  <= WORD_W'(d_wdata);
            end else begin
              if_ready <= 1'b1;
              gnt_q    <= PORT_FETCH;
              last_gnt <= PORT_FETCH;
              addr_q   <= if_addr;
              size_q   <= 2'd2;
              we_q     <= 1'b0;
              wdata_q  <= '0;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= RESP;
        end
        RESP: begin
          if (gnt_q == PORT_DATA) begin
            d_valid <= 1'b1;
            d_rdata <= DATA_W'(rd_data);
            d_fault <= fault;
          end else begin
            if_valid <= 1'b1;
            if_instr <= rd_data[31:0];
            if_fault <= fault;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tinker_mem_ctrl.sv
// Directed self-checking bench for tinker_mem_ctrl (default parameters, WAIT_STATES = 2).
module tb_tinker_mem_ctrl;

  localparam int unsigned ADDR_W      = 19;
  localparam int unsigned DATA_W      = 64;
  localparam int unsigned WAIT_STATES = 2;

  logic              clk;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic              if_valid;
  logic [31:0]       if_instr;
  logic              if_fault;
  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_fault;

  int n_cmp = 0;
  int n_err = 0;

  tinker_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_STATES(WAIT_STATES)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_valid(if_valid),
    .if_instr(if_instr), .if_fault(if_fault),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_valid(d_valid), .d_rdata(d_rdata), .d_fault(d_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_ctl"}, 64'({if_ready, if_valid, if_fault, d_ready, d_valid, d_fault}), 64'd0);
    check({tag, "_d_rdata"}, d_rdata, 64'd0);
    check({tag, "_if_instr"}, 64'(if_instr), 64'd0);
  endtask

  task automatic d_xact(input logic we, input logic [1:0] size, input logic [ADDR_W-1:0] addr,
                        input logic [63:0] wdata, output logic [63:0] rdata, output logic fault);
    logic ok;
    int   lat;
    @(negedge clk);
    d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (d_ready) begin ok = 1'b1; break; end
    end
    d_req = 1'b0; d_we = 1'b0; d_size = 2'd0; d_addr = '0; d_wdata = '0;
    check("d_ready_seen", 64'(ok), 64'd1);
    ok = 1'b0; lat = 0;
    for (int c = 1; c < 50; c++) begin
      @(posedge clk); #1;
      if (d_valid) begin ok = 1'b1; lat = c; break; end
    end
    check("d_valid_seen", 64'(ok), 64'd1);
    check("d_latency", 64'(lat), 64'(WAIT_STATES + 1));
    rdata = d_rdata;
    fault = d_fault;
    @(posedge clk); #1;
    check("d_valid_pulse", 64'(d_valid), 64'd0);
  endtask

  task automatic if_xact(input logic [ADDR_W-1:0] addr, output logic [31:0] instr, output logic fault);
    logic ok;
    int   lat;
    @(negedge clk);
    if_req = 1'b1; if_addr = addr;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (if_ready) begin ok = 1'b1; break; end
    end
    if_req = 1'b0; if_addr = '0;
    check("if_ready_seen", 64'(ok), 64'd1);
    ok = 1'b0; lat = 0;
    for (int c = 1; c < 50; c++) begin
      @(posedge clk); #1;
      if (if_valid) begin ok = 1'b1; lat = c; break; end
    end
    check("if_valid_seen", 64'(ok), 64'd1);
    check("if_latency", 64'(lat), 64'(WAIT_STATES + 1));
    instr = if_instr;
    fault = if_fault;
    @(posedge clk); #1;
    check("if_valid_pulse", 64'(if_valid), 64'd0);
  endtask

  // Store accepted, then reset lands n_edges after accept (1 = BUSY, 2 = RESP cycle).
  task automatic reset_mid(input int n_edges, input string tag);
    logic ok;
    int   seen_valid;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_size = 2'd2; d_addr = 19'h02000; d_wdata = 64'hDEADBEEF;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (d_ready) begin ok = 1'b1; break; end
    end
    d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    check({tag, "_ready"}, 64'(ok), 64'd1);
    repeat (n_edges) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    check_outs_zero({tag, "_in_reset"});
    seen_valid = 0;
    repeat (3) begin @(posedge clk); #1; if (d_valid) seen_valid++; end
    @(negedge clk);
    reset = 1'b1;
    repeat (6) begin @(posedge clk); #1; if (d_valid) seen_valid++; end
    check({tag, "_no_valid"}, 64'(seen_valid), 64'd0);
  endtask

  logic [63:0] rd;
  logic        flt;
  logic [31:0] ins;
  int          n_gr;
  int          gcyc [4];
  logic [1:0]  gport [4];
  int          both_rdy;

  initial begin
    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'd0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    check_outs_zero("reset");
    reset = 1'b1;

    // Store then load, 8 bytes, plus narrow loads that must zero-extend.
    d_xact(1'b1, 2'd3, 19'h02000, 64'h1122334455667788, rd, flt);
    check("st8_fault", 64'(flt), 64'd0);
    d_xact(1'b0, 2'd3, 19'h02000, 64'd0, rd, flt);
    check("ld8_data", rd, 64'h1122334455667788);
    check("ld8_fault", 64'(flt), 64'd0);
    d_xact(1'b0, 2'd0, 19'h02001, 64'd0, rd, flt);
    check("ld1_data", rd, 64'h77);
    d_xact(1'b0, 2'd1, 19'h02006, 64'd0, rd, flt);
    check("ld2_data", rd, 64'h1122);

    // Instruction bytes 13 00 40 C8 at 0x2000, then fetch.
    d_xact(1'b1, 2'd2, 19'h02000, 64'hFFFF_FFFF_C840_0013, rd, flt);
    if_xact(19'h02000, ins, flt);
    check("fetch_instr", 64'(ins), 64'hC8400013);
    check("fetch_fault", 64'(flt), 64'd0);
    d_xact(1'b0, 2'd3, 19'h02000, 64'd0, rd, flt);
    check("st4_upper_kept", rd, 64'h11223344C8400013);
    check("if_instr_hold", 64'(if_instr), 64'hC8400013);

    // 4-byte load straddling a word boundary.
    d_xact(1'b0, 2'd2, 19'h02002, 64'd0, rd, flt);
`ifdef TINKER_MEM_ALIGN_CHECK_EN
    check("misalign_fault", 64'(flt), 64'd1);
    check("misalign_data", rd, 64'd0);
`else
    check("misalign_fault", 64'(flt), 64'd0);
    check("misalign_data", rd, 64'h3344C840);
`endif

    // Top-of-array boundary and out-of-range faults.
    d_xact(1'b1, 2'd1, 19'h7FFFE, 64'hBEEF, rd, flt);
    check("edge_st2_fault", 64'(flt), 64'd0);
    d_xact(1'b0, 2'd2, 19'h7FFFE, 64'd0, rd, flt);
    check("oor_ld4_fault", 64'(flt), 64'd1);
    check("oor_ld4_data", rd, 64'd0);
    d_xact(1'b1, 2'd3, 19'h7FFFE, 64'hFFFF_FFFF_FFFF_FFFF, rd, flt);
    check("oor_st8_fault", 64'(flt), 64'd1);
    d_xact(1'b0, 2'd1, 19'h7FFFE, 64'd0, rd, flt);
    check("edge_ld2_data", rd, 64'hBEEF);
    check("edge_ld2_fault", 64'(flt), 64'd0);
    d_xact(1'b0, 2'd0, 19'h7FFFF, 64'd0, rd, flt);
    check("edge_ld1_data", rd, 64'hBE);
    if_xact(19'h7FFFE, ins, flt);
    check("oor_fetch_fault", 64'(flt), 64'd1);
    check("oor_fetch_instr", 64'(ins), 64'd0);

    // Reset mid-transaction must abort the store.
    reset_mid(1, "rst_busy");
    d_xact(1'b0, 2'd2, 19'h02000, 64'd0, rd, flt);
    check("rst_busy_no_write", rd, 64'hC8400013);
    reset_mid(2, "rst_resp");
    d_xact(1'b0, 2'd2, 19'h02000, 64'd0, rd, flt);
    check("rst_resp_no_write", rd, 64'hC8400013);

    // Arbitration: both requesters held high from reset release.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 19'h02000;
    if_req = 1'b1; if_addr = 19'h02004;
    @(negedge clk);
    reset = 1'b1;
    n_gr = 0; both_rdy = 0;
    for (int i = 0; i < 4; i++) begin gcyc[i] = -1; gport[i] = 2'd3; end
    for (int c = 0; c < 40 && n_gr < 4; c++) begin
      @(posedge clk); #1;
      if (d_ready && if_ready) both_rdy++;
      if (d_ready || if_ready) begin
        gport[n_gr] = d_ready ? 2'd1 : 2'd0;
        gcyc[n_gr]  = c;
        n_gr++;
      end
      if (d_valid) check("arb_d_rdata", d_rdata, 64'hC8400013);
      if (if_valid) check("arb_if_instr", 64'(if_instr), 64'h11223344);
    end
    d_req = 1'b0; if_req = 1'b0;
    repeat (6) @(posedge clk);
    check("arb_grants", 64'(n_gr), 64'd4);
    check("arb_both_ready", 64'(both_rdy), 64'd0);
    check("arb_order", 64'({gport[0], gport[1], gport[2], gport[3]}), 64'b01_00_01_00);
    check("arb_gap1", 64'(gcyc[1] - gcyc[0]), 64'(WAIT_STATES + 2));
    check("arb_gap2", 64'(gcyc[2] - gcyc[1]), 64'(WAIT_STATES + 2));
    check("arb_gap3", 64'(gcyc[3] - gcyc[2]), 64'(WAIT_STATES + 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
